snake_head_mover: RTL

Consumes the direction request produced by the turn logic and advances the snake's head one grid cell per game tick. It owns the authoritative `current_direction`, which feeds back to the turn logic, and the head coordinates used by body, food and display logic. It contains the game-speed divider and the run/pause/dead state machine.

---
 rtl/snake_pkg.sv | 30 +++
 rtl/snake_head_mover_step_timer.sv | 42 ++++
 rtl/snake_head_mover.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// ============================================================================
// Module      : snake_pkg
// Description : Shared direction/state types and helpers for the snake game.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        RIGHT = 2'b01,
        DOWN  = 2'b10,
        LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DEAD = 2'b10
    } state_t;

    // Opposite directions differ only in the upper encoding bit.
    function automatic logic is_opposite(input dir_t a, input dir_t b);
        return (a ^ b) == 2'b10;
    endfunction

endpackage

`default_nettype wire

// File: rtl/snake_head_mover_step_timer.sv
// ============================================================================
// Module      : step_timer
// Description : Game-speed divider; pulses tick every STEP_DIV enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_timer #(
    parameter int STEP_DIV = 25_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int               c_CW   = $clog2(STEP_DIV);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(STEP_DIV - 1);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (r_count == c_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + c_CW'(1);
            end
        end
    end

    // Combinational so the step lands in the cycle right after the tick.
    assign tick = enable && (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/snake_head_mover.sv
// ============================================================================
// Module      : snake_head_mover
// Description : Advances the snake head one cell per tick; run/pause/dead FSM.
//               SNAKE_WALL_WRAP_EN: defined = edges wrap, undefined = fatal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_head_mover
    import snake_pkg::*;
#(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int STEP_DIV = 25_000_000,
    parameter int START_X  = 20,
    parameter int START_Y  = 15
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      pause,
    input  logic [1:0]                next_direction,
    output logic [1:0]                current_direction,
    output logic [$clog2(GRID_W)-1:0] head_x,
    output logic [$clog2(GRID_H)-1:0] head_y,
    output logic                      step,
    output logic                      dead
);

    localparam int              c_XW      = $clog2(GRID_W);
    localparam int              c_YW      = $clog2(GRID_H);
    localparam logic [c_XW-1:0] c_X_MAX   = c_XW'(GRID_W - 1);
    localparam logic [c_YW-1:0] c_Y_MAX   = c_YW'(GRID_H - 1);
    localparam logic [c_XW-1:0] c_X_START = c_XW'(START_X);
    localparam logic [c_YW-1:0] c_Y_START = c_YW'(START_Y);

    state_t          r_state;
    dir_t            r_dir;
    logic [c_XW-1:0] r_x;
    logic [c_YW-1:0] r_y;
    logic            r_step;
    logic            r_dead;

    logic            w_tick;
    logic            w_enable;
    logic            w_clear;
    dir_t            w_req;
    dir_t            w_dir;
    logic            w_at_edge;
    logic            w_fatal;
    logic [c_XW-1:0] w_next_x;
    logic [c_YW-1:0] w_next_y;

    assign w_enable = (r_state == RUN) && !pause;
    assign w_clear  = (r_state != RUN);

    step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (w_enable),
        .clear   (w_clear),
        .tick    (w_tick)
    );

    assign w_req = dir_t'(next_direction);
    assign w_dir = is_opposite(w_req, r_dir) ? r_dir : w_req;

    // Candidate next cell, already wrapped; the no-wrap build treats the edge as fatal.
    always_comb begin
        w_next_x  = r_x;
        w_next_y  = r_y;
        w_at_edge = 1'b0;
        case (w_dir)
            UP: begin
                w_at_edge = (r_y == '0);
                w_next_y  = w_at_edge ? c_Y_MAX : r_y - c_YW'(1);
            end
            DOWN: begin
                w_at_edge = (r_y == c_Y_MAX);
                w_next_y  = w_at_edge ? '0 : r_y + c_YW'(1);
            end
            LEFT: begin
                w_at_edge = (r_x == '0);
                w_next_x  = w_at_edge ? c_X_MAX : r_x - c_XW'(1);
            end
            default: begin
                w_at_edge = (r_x == c_X_MAX);
                w_next_x  = w_at_edge ? '0 : r_x + c_XW'(1);
            end
        endcase
`ifdef SNAKE_WALL_WRAP_EN
        w_fatal = 1'b0;
`else
        w_fatal = w_at_edge;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_dir   <= RIGHT;
            r_x     <= c_X_START;
            r_y     <= c_Y_START;
            r_step  <= 1'b0;
            r_dead  <= 1'b0;
        end else begin
            r_step <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_tick) begin
                        r_dir <= w_dir;
                        if (w_fatal) begin
                            r_state <= DEAD;
                            r_dead  <= 1'b1;
                        end else begin
                            r_x    <= w_next_x;
                            r_y    <= w_next_y;
                            r_step <= 1'b1;
                        end
                    end
                end
                DEAD: begin
                    if (start) begin
                        r_state <= RUN;
                        r_dir   <= RIGHT;
                        r_x     <= c_X_START;
                        r_y     <= c_Y_START;
                        r_dead  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign current_direction = r_dir;
    assign head_x            = r_x;
    assign head_y            = r_y;
    assign step              = r_step;
    assign dead              = r_dead;

endmodule

`default_nettype wire
